bids22_host: RTL

BIDS22_HOST -- requirements
Module: bids22_host

---
 rtl/bids22_host_if.sv | 30 +++
 rtl/bids22_host.sv | 110 +++++++++++
 2 files changed

// File: rtl/bids22_host_if.sv
// bids22_host_if: command, auction-core and response signals of the bids22 host
interface bids22_host_if #(
    parameter int DATAWIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_kind;
    logic [3:0]           req_op;
    logic [DATAWIDTH-1:0] req_data;
    logic [3:0]           C_op;
    logic [DATAWIDTH-1:0] C_data;
    logic                 C_start;
    logic                 ready;
    logic [2:0]           err;
    logic                 roundOver;
    logic [DATAWIDTH-1:0] maxBid;
    logic                 rsp_valid;
    logic [2:0]           rsp_err;
    logic [DATAWIDTH-1:0] rsp_maxbid;

    modport master (
        input  req_valid, req_kind, req_op, req_data, ready, err, roundOver, maxBid,
        output req_ready, C_op, C_data, C_start, rsp_valid, rsp_err, rsp_maxbid
    );

    modport slave (
        output req_valid, req_kind, req_op, req_data, ready, err, roundOver, maxBid,
        input  req_ready, C_op, C_data, C_start, rsp_valid, rsp_err, rsp_maxbid
    );
endinterface

// File: rtl/bids22_host.sv
// bids22_host: sequences config, lock/unlock and bidding rounds on an auction core; BIDS22_HOST_STATS_EN adds err_count
module bids22_host #(
    parameter int DATAWIDTH = 32,
    parameter int WAITMAX   = 255
) (
    input logic clk,
    input logic reset_n,
    bids22_host_if.master bus
`ifdef BIDS22_HOST_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);
    localparam int CW = ($clog2(WAITMAX + 1) > 16) ? $clog2(WAITMAX + 1) : 16;
    localparam logic [1:0] K_CFG = 2'd0, K_LOCK = 2'd1, K_UNLOCK = 2'd2, K_ROUND = 2'd3;
    localparam logic [3:0] OP_NO = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_MAX = 4'd8;

    typedef enum logic [2:0] {IDLE, ISSUE, KEYWAIT, START, DRAIN, RESP} state_t;

    state_t               state, state_n;
    logic [1:0]           kind;
    logic [3:0]           op;
    logic [DATAWIDTH-1:0] data;
    logic [CW-1:0]        cnt;
    logic [15:0]          n_round;
    logic [2:0]           rsp_err;
    logic [DATAWIDTH-1:0] rsp_maxbid;
    logic                 bad_cfg, wait_done, start_last, drain_hit;

    assign bad_cfg    = bus.req_kind == K_CFG && (bus.req_op == OP_NO || bus.req_op > OP_MAX);
    assign n_round    = data[15:0] == 16'd0 ? 16'd1 : data[15:0];
    assign start_last = cnt == CW'(n_round - 16'd1);
    assign wait_done  = cnt == CW'(WAITMAX);
    assign drain_hit  = cnt != '0 && (bus.roundOver || bus.ready);

    assign bus.req_ready  = state == IDLE;
    assign bus.C_start    = state == START;
    assign bus.C_op       = state != ISSUE ? OP_NO : kind == K_CFG ? op : kind == K_LOCK ? OP_LOCK : OP_UNLOCK;
    assign bus.C_data     = state == ISSUE ? data : '0;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_err    = rsp_err;
    assign bus.rsp_maxbid = rsp_maxbid;

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.req_valid) state_n = bad_cfg ? RESP : bus.req_kind == K_ROUND ? START : ISSUE;
            ISSUE:   state_n = kind == K_UNLOCK ? KEYWAIT : RESP;
            KEYWAIT: if (bus.err == 3'd0 || wait_done) state_n = RESP;
            START:   if (start_last) state_n = DRAIN;
            DRAIN:   if (drain_hit || wait_done) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // command latch, phase counter and response capture
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            kind       <= '0;
            op         <= '0;
            data       <= '0;
            cnt        <= '0;
            rsp_err    <= '0;
            rsp_maxbid <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    kind <= bus.req_kind;
                    op   <= bus.req_op;
                    data <= bus.req_data;
                    cnt  <= '0;
                    if (bad_cfg) rsp_err <= 3'b110;
                end
                ISSUE: begin
                    rsp_err <= bus.err;
                    cnt     <= '0;
                end
                KEYWAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.err == 3'd0) begin
                        if (cnt == '0) rsp_err <= 3'd0;
                    end else if (wait_done) rsp_err <= 3'b111;
                    else if (cnt == '0) rsp_err <= bus.err;
                end
                START: cnt <= start_last ? '0 : cnt + 1'b1;
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (drain_hit) begin
                        rsp_maxbid <= bus.maxBid;
                        rsp_err    <= bus.err;
                    end else if (wait_done) rsp_err <= 3'b111;
                end
                default: ;
            endcase
        end

`ifdef BIDS22_HOST_STATS_EN
    // count completions reporting an error, saturating
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) err_count <= '0;
        else if (state == RESP && rsp_err != 3'd0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule
